// File: rtl/pixel_pkg.sv
// Shared types, mode codes and LFSR helpers for the pixel hit recorder.
// The LFSR helpers back the PIXEL_LFSR_COUNTER_EN counter encoding.
package pixel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_MEAS  = 2'b10,
    ST_HOLD  = 2'b11
  } pix_state_e;

  localparam logic [1:0] MODE_TOA  = 2'b00;
  localparam logic [1:0] MODE_CNT  = 2'b01;
  localparam logic [1:0] MODE_ITOT = 2'b10;

  // Maximal-length XNOR taps for a left-shifting LFSR, feedback into bit 0.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      default: t = 16'hD008;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] width_mask(input int w);
    return 16'((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input int w);
    logic fb;
    fb = ~^(s & lfsr_taps(w));
    return ((s << 1) | {15'd0, fb}) & width_mask(w);
  endfunction

  // State reached from the all-zero seed after 2^w-2 steps (saturation point).
  function automatic logic [15:0] lfsr_sat_state(input int w);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < (1 << w) - 2; i++) begin
      s = lfsr_next(s, w);
    end
    return s;
  endfunction

endpackage

// File: rtl/pixel_hit_recorder_sat_counter.sv
// Saturating clear/load/increment counter, binary by default or XNOR LFSR
// encoded when PIXEL_LFSR_COUNTER_EN is defined.
module pixel_sat_counter
  import pixel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_one_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d, cnt_step;
  logic         sat_q;

`ifdef PIXEL_LFSR_COUNTER_EN
  localparam logic [15:0]  TAPS16  = lfsr_taps(W);
  localparam logic [15:0]  SAT16   = lfsr_sat_state(W);
  localparam logic [W-1:0] TAPS    = TAPS16[W-1:0];
  localparam logic [W-1:0] CNT_MAX = SAT16[W-1:0];

  // One step from the all-zero seed is 0...01, so CNT_ONE is valid here too.
  assign cnt_step = {cnt_q[W-2:0], ~^(cnt_q & TAPS)};
`else
  localparam logic [W-1:0] CNT_MAX = '1;

  assign cnt_step = cnt_q + CNT_ONE;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = CNT_ONE;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == CNT_MAX);
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pixel_hit_recorder.sv
// Per-pixel hit recorder: ToA+ToT, event count or integrated ToT within the
// shutter window, result held until acked. Counter encoding: PIXEL_LFSR_COUNTER_EN.
//
// state | meaning
// IDLE  | shutter closed, nothing pending
// ARMED | shutter open, waiting for a synchronised hit edge
// MEAS  | measurement running
// HOLD  | result valid, waiting for data_ack
module pixel_hit_recorder
  import pixel_pkg::*;
#(
  parameter int TOT_W       = 8,
  parameter int TS_W        = 9,
  parameter int FTOA_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_gating_pixel_40MHz,
  input  logic              out_flag,
  input  logic              shutter,
  input  logic [1:0]        mode,
  input  logic              mask,
  input  logic              hit_pixel,
  input  logic [TS_W-1:0]   TimeStamp,
  input  logic [FTOA_W-1:0] ftoa_in,
  input  logic              data_ack,
  output logic              data_valid,
  output logic              hit_busy,
  output logic [TOT_W-1:0]  ToT_data,
  output logic [TS_W-1:0]   timestamp_hit,
  output logic [FTOA_W-1:0] FTOA,
  output logic              overflow
);

  logic [SYNC_STAGES-1:0] hit_sync_q;
  logic                   hit_prev_q;
  logic                   shutter_q;
  logic [1:0]             mode_q;
  pix_state_e             state_q;
  logic                   data_valid_q;
  logic                   hit_busy_q;
  logic [TS_W-1:0]        ts_q;
  logic [FTOA_W-1:0]      ftoa_q;

  logic hit_s, hit_rise, hit_fall;
  logic window_mode, start_meas, meas_done, cnt_inc, cnt_clr;

  assign hit_s    = hit_sync_q[SYNC_STAGES-1];
  assign hit_rise = hit_s && !hit_prev_q;
  assign hit_fall = !hit_s && hit_prev_q;

  // Count and iToT close on the shutter; ToA (and the unused code 11) on the hit.
  assign window_mode = (mode_q == MODE_CNT) || (mode_q == MODE_ITOT);
  assign start_meas  = (state_q == ST_ARMED) && shutter && hit_rise && !mask;
  assign meas_done   = window_mode ? !shutter : hit_fall;
  assign cnt_inc     = (state_q == ST_MEAS) && !meas_done &&
                       ((mode_q == MODE_CNT) ? hit_rise : hit_s);
  assign cnt_clr     = (state_q == ST_HOLD) && data_ack;

  always_ff @(posedge clk_gating_pixel_40MHz) begin
    if (out_flag) begin
      hit_sync_q   <= '0;
      hit_prev_q   <= 1'b0;
      shutter_q    <= 1'b0;
      mode_q       <= MODE_TOA;
      state_q      <= ST_IDLE;
      data_valid_q <= 1'b0;
      hit_busy_q   <= 1'b0;
      ts_q         <= '0;
      ftoa_q       <= '0;
    end else begin
      hit_sync_q <= {hit_sync_q[SYNC_STAGES-2:0], hit_pixel};
      hit_prev_q <= hit_s;
      shutter_q  <= shutter;
      if (shutter && !shutter_q) begin
        mode_q <= mode;
      end

      case (state_q)
        ST_IDLE: begin
          if (shutter) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!shutter) begin
            state_q <= ST_IDLE;
          end else if (start_meas) begin
            state_q    <= ST_MEAS;
            hit_busy_q <= 1'b1;
            ts_q       <= TimeStamp;
            ftoa_q     <= ftoa_in;
          end
        end
        ST_MEAS: begin
          if (meas_done) begin
            state_q      <= ST_HOLD;
            data_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (data_ack) begin
            state_q      <= shutter ? ST_ARMED : ST_IDLE;
            data_valid_q <= 1'b0;
            hit_busy_q   <= 1'b0;
            ts_q         <= '0;
            ftoa_q       <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pixel_sat_counter #(
    .W(TOT_W)
  ) u_tot_cnt (
    .clk_i      (clk_gating_pixel_40MHz),
    .rst_i      (out_flag),
    .clr_i      (cnt_clr),
    .load_one_i (start_meas),
    .inc_i      (cnt_inc),
    .cnt_o      (ToT_data),
    .sat_o      (overflow)
  );

  assign data_valid    = data_valid_q;
  assign hit_busy      = hit_busy_q;
  assign timestamp_hit = ts_q;
  assign FTOA          = ftoa_q;

endmodule
